// File: rtl/audio_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------+
// | audio_pkg : shared fetch-FSM states and sample-word field layout  |
// | Revision  : 1.0                                                   |
// +-------------------------------------------------------------------+
package audio_pkg;
  localparam int SAMPLE_W  = 16;
  localparam int LEFT_MSB  = 31;
  localparam int RIGHT_MSB = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } fetch_state_t;
endpackage
`default_nettype wire

// File: rtl/i2s_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------+
// | i2s_tx   : codec-clock synchronisers and I2S DAC serialiser       |
// | Revision : 1.0                                                    |
// +-------------------------------------------------------------------+
module i2s_tx
  import audio_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                aud_bclk,
  input  logic                aud_daclrck,
  input  logic [SAMPLE_W-1:0] left_in,
  input  logic [SAMPLE_W-1:0] right_in,
  output logic                frame_start,
  output logic                aud_dacdat
);

  logic [1:0]          bclk_sync;
  logic [1:0]          lrck_sync;
  logic                bclk_prev;
  logic                lrck_prev;
  logic                bclk_fall;
  logic                lrck_fall;
  logic                lrck_rise;
  logic [SAMPLE_W-1:0] shift_reg;
  logic [SAMPLE_W-1:0] right_hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync <= 2'b00;
      lrck_sync <= 2'b00;
      bclk_prev <= 1'b0;
      lrck_prev <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], aud_bclk};
      lrck_sync <= {lrck_sync[0], aud_daclrck};
      bclk_prev <= bclk_sync[1];
      lrck_prev <= lrck_sync[1];
    end
  end

  assign bclk_fall   = bclk_prev & ~bclk_sync[1];
  assign lrck_fall   = lrck_prev & ~lrck_sync[1];
  assign lrck_rise   = ~lrck_prev & lrck_sync[1];
  assign frame_start = lrck_fall;

  // The BCLK fall that carries the LRCK change emits the I2S delay slot (0);
  // the MSB follows on the next fall, and zeros are shifted in behind the LSB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg  <= '0;
      right_hold <= '0;
      aud_dacdat <= 1'b0;
    end else if (lrck_fall) begin
      shift_reg  <= left_in;
      right_hold <= right_in;
      aud_dacdat <= 1'b0;
    end else if (lrck_rise) begin
      shift_reg  <= right_hold;
      aud_dacdat <= 1'b0;
    end else if (bclk_fall) begin
      aud_dacdat <= shift_reg[SAMPLE_W-1];
      shift_reg  <= {shift_reg[SAMPLE_W-2:0], 1'b0};
    end
  end

endmodule
`default_nettype wire

// File: rtl/audio_player.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------+
// | audio_player : ring-buffer sample fetch feeding an I2S DAC stream |
// | Revision     : 1.0                                                |
// +-------------------------------------------------------------------+
module audio_player
  import audio_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  input  logic [31:0]       mem_readdata,
  input  logic [31:0]       position_end,
  output logic [31:0]       position,
  input  logic              aud_bclk,
  input  logic              aud_daclrck,
  output logic              aud_dacdat,
  output logic              underrun
);

  fetch_state_t        state;
  logic [31:0]         prefetch;
  logic                prefetch_valid;
  logic                frame_start;
  logic                consume;
  logic [SAMPLE_W-1:0] left_load;
  logic [SAMPLE_W-1:0] right_load;

  assign mem_clken      = 1'b1;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_address    = position[ADDR_W-1:0];
  assign mem_chipselect = (state == ST_REQ);

  assign consume    = frame_start & enable & prefetch_valid;
  assign left_load  = consume ? prefetch[LEFT_MSB -: SAMPLE_W]  : '0;
  assign right_load = consume ? prefetch[RIGHT_MSB -: SAMPLE_W] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && !prefetch_valid && (position != position_end))
            state <= ST_REQ;
        end
        ST_REQ:     state <= ST_WAIT;
        ST_WAIT:    state <= ST_CAPTURE;
        ST_CAPTURE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // A frame start landing on CAPTURE sees valid still low and plays silence;
  // the capture then survives for the following frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      position       <= '0;
      prefetch       <= '0;
      prefetch_valid <= 1'b0;
      underrun       <= 1'b0;
    end else begin
      underrun <= frame_start & enable & ~prefetch_valid;
      if (consume) begin
        position       <= position + 32'd1;
        prefetch_valid <= 1'b0;
      end
      if (state == ST_CAPTURE) begin
        prefetch       <= mem_readdata;
        prefetch_valid <= 1'b1;
      end
    end
  end

  i2s_tx u_i2s_tx (
    .clk         (clk),
    .reset_n     (reset_n),
    .aud_bclk    (aud_bclk),
    .aud_daclrck (aud_daclrck),
    .left_in     (left_load),
    .right_in    (right_load),
    .frame_start (frame_start),
    .aud_dacdat  (aud_dacdat)
  );

endmodule
`default_nettype wire

// File: tb/tb_audio_player.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_audio_player : codec/memory model with frame-level scoreboard  |
// | Revision        : 1.0                                             |
// +-------------------------------------------------------------------+
module tb_audio_player;

  // Small address space so the memory wrap is reachable in a short run.
  localparam int AW            = 4;
  localparam int MEM_WORDS     = 1 << AW;
  localparam int HALF_BCLK     = 100;
  localparam int BITS_PER_HALF = 18;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [AW-1:0] mem_address;
  logic          mem_chipselect;
  logic          mem_clken;
  logic          mem_write;
  logic [3:0]    mem_byteenable;
  logic [31:0]   mem_readdata;
  logic [31:0]   position_end;
  logic [31:0]   position;
  logic          aud_bclk;
  logic          aud_daclrck;
  logic          aud_dacdat;
  logic          underrun;

  always #10 clk = ~clk;

  audio_player #(.ADDR_W(AW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_clken      (mem_clken),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_readdata   (mem_readdata),
    .position_end   (position_end),
    .position       (position),
    .aud_bclk       (aud_bclk),
    .aud_daclrck    (aud_daclrck),
    .aud_dacdat     (aud_dacdat),
    .underrun       (underrun)
  );

  logic [31:0] mem [MEM_WORDS];

  always @(posedge clk) begin
    if (mem_chipselect) mem_readdata <= mem[mem_address];
  end

  int n_cmp = 0;
  int n_bad = 0;
  int ur_cnt = 0;
  int cs_cnt = 0;
  int rd_log[$];

  always @(negedge clk) begin
    if (underrun) ur_cnt <= ur_cnt + 1;
    if (mem_chipselect) begin
      cs_cnt <= cs_cnt + 1;
      rd_log.push_back(int'(mem_address));
    end
  end

  logic [31:0] model_pos;
  logic [31:0] model_end;
  logic        model_en;
  logic        allow_gap;
  int          gaps;
  int          nogaps;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Expected frame content follows from the ring-buffer rule alone: an enabled
  // frame plays mem[pos mod size] if pos != end, otherwise silence + underrun.
  task automatic check_frame(input logic [BITS_PER_HALF-1:0] lb,
                             input logic [BITS_PER_HALF-1:0] rb, input int ur);
    logic [31:0] exp_word;
    int          exp_ur;
    logic [15:0] l;
    logic [15:0] r;
    l        = lb[16:1];
    r        = rb[16:1];
    exp_word = 32'h0;
    exp_ur   = 0;
    if (model_en) begin
      if (model_pos != model_end) begin
        if (allow_gap && l == 16'h0 && r == 16'h0) begin
          exp_ur = 1;
          gaps++;
        end else begin
          exp_word = mem[model_pos % MEM_WORDS];
          if (allow_gap) nogaps++;
          model_pos = model_pos + 32'd1;
        end
        allow_gap = 1'b0;
      end else begin
        exp_ur = 1;
      end
    end
    check_eq("left", {16'h0, l}, {16'h0, exp_word[31:16]});
    check_eq("right", {16'h0, r}, {16'h0, exp_word[15:0]});
    check_eq("pad_bits", {28'h0, lb[17], lb[0], rb[17], rb[0]}, 32'h0);
    check_eq("underrun_count", ur, exp_ur);
    check_eq("position", position, model_pos);
  endtask

  // Codec master: LRCK changes on BCLK falls; DACDAT sampled just before each rise.
  task automatic play_frames(input int n);
    logic [BITS_PER_HALF-1:0] bits [2];
    int ur0;
    for (int f = 0; f < n; f++) begin
      ur0 = ur_cnt;
      for (int ch = 0; ch < 2; ch++) begin
        for (int b = 0; b < BITS_PER_HALF; b++) begin
          aud_bclk = 1'b0;
          if (b == 0) aud_daclrck = (ch == 1);
          #HALF_BCLK;
          bits[ch][BITS_PER_HALF-1-b] = aud_dacdat;
          aud_bclk = 1'b1;
          #HALF_BCLK;
        end
      end
      check_frame(bits[0], bits[1], ur_cnt - ur0);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_end(input logic [31:0] v);
    position_end = v;
    model_end    = v;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got time limit reached, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cs0;
    int n;
    int t;
    aud_bclk    = 1'b1;
    aud_daclrck = 1'b1;
    reset_n     = 1'b0;
    enable      = 1'b0;
    position_end = 32'h0;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom | 32'h0001_0001;
    mem[0]    = 32'h1234_ABCD;
    model_pos = 32'h0;
    model_end = 32'h0;
    model_en  = 1'b0;
    allow_gap = 1'b0;
    gaps      = 0;
    nogaps    = 0;

    #35;
    check_eq("rst_position", position, 32'h0);
    check_eq("rst_chipselect", {31'h0, mem_chipselect}, 32'h0);
    check_eq("rst_dacdat", {31'h0, aud_dacdat}, 32'h0);
    check_eq("rst_underrun", {31'h0, underrun}, 32'h0);
    check_eq("tie_clken", {31'h0, mem_clken}, 32'h1);
    check_eq("tie_write", {31'h0, mem_write}, 32'h0);
    check_eq("tie_byteen", {28'h0, mem_byteenable}, 32'hF);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Empty buffer: silence and one underrun per frame, no reads.
    enable   = 1'b1;
    model_en = 1'b1;
    cs0 = cs_cnt;
    wait_ticks(8);
    play_frames(3);
    check_eq("empty_reads", cs_cnt - cs0, 32'h0);

    // First samples, starting with 0x1234_ABCD at address 0.
    cs0 = cs_cnt;
    set_end(32'd4);
    wait_ticks(8);
    play_frames(5);
    check_eq("fill_reads", cs_cnt - cs0, 32'd4);

    // Pause at position 7, then resume.
    set_end(32'd12);
    wait_ticks(8);
    play_frames(3);
    enable   = 1'b0;
    model_en = 1'b0;
    play_frames(2);
    enable   = 1'b1;
    model_en = 1'b1;
    wait_ticks(8);
    play_frames(5);

    // Address wrap: positions 12..16 read addresses 12..15 then 0.
    set_end(32'd17);
    wait_ticks(8);
    play_frames(6);
    n = rd_log.size();
    check_eq("wrap_reads_seen", {31'h0, n >= 2}, 32'h1);
    if (n >= 2) begin
      check_eq("wrap_addr_a", rd_log[n-2], 32'd15);
      check_eq("wrap_addr_b", rd_log[n-1], 32'd0);
    end

    // Reset asserted while a read is in flight (cycle after the strobe).
    set_end(32'd20);
    t = 0;
    while (!mem_chipselect && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("cs_seen", {31'h0, mem_chipselect}, 32'h1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("midfetch_cs", {31'h0, mem_chipselect}, 32'h0);
    check_eq("midfetch_position", position, 32'h0);
    check_eq("midfetch_dacdat", {31'h0, aud_dacdat}, 32'h0);
    check_eq("midfetch_underrun", {31'h0, underrun}, 32'h0);
    set_end(32'h0);
    model_pos = 32'h0;
    wait_ticks(3);
    reset_n = 1'b1;
    wait_ticks(8);
    play_frames(1);

    // Sweep the frame start across the fetch so one lands on the capture.
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      set_end(model_pos + 32'd1);
      allow_gap = 1'b1;
      wait_ticks(k);
      play_frames(2);
    end
    check_eq("gap_seen", {31'h0, gaps > 0}, 32'h1);
    check_eq("nogap_seen", {31'h0, nogaps > 0}, 32'h1);

    // Random producer advances and enable toggles.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) begin
        enable   = ~enable;
        model_en = enable;
      end else begin
        set_end(position_end + $urandom_range(0, 3));
      end
      wait_ticks(8);
      play_frames($urandom_range(1, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
